// File: rtl/wb_timer.sv
// Wishbone slave timer: prescaled 16-bit up-counter with compare match, auto-reload and irq.
// Latency: ack and read data one cycle after an accepted strobe; irq follows MATCH by zero cycles.
// Backpressure: none; one transfer per cycle is accepted with no stall or wait state.
module wb_timer #(
    parameter logic [15:0] BASE_ADR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] adr,
    input  logic        cyc,
    input  logic        stb,
    input  logic        we,
    input  logic [15:0] dat_i,
    output logic [15:0] dat_o,
    output logic        ack,
    output logic        irq
);

    localparam logic [2:0] REG_CTRL    = 3'd0;
    localparam logic [2:0] REG_STATUS  = 3'd1;
    localparam logic [2:0] REG_COUNT   = 3'd2;
    localparam logic [2:0] REG_COMPARE = 3'd3;

    logic        acc;
    logic        wr;
    logic        wr_ctrl;
    logic        wr_status;
    logic        wr_count;
    logic        wr_compare;

    logic        en;
    logic        auto_reload;
    logic        irq_en;
    logic [7:0]  prescale;
    logic [7:0]  pcnt;
    logic [15:0] count;
    logic [15:0] compare;
    logic        match;

    logic        tick;
    logic        hit;
    logic [15:0] count_inc;
    logic [15:0] rd_dat;

    assign acc        = cyc & stb & (adr[15:3] == BASE_ADR[15:3]);
    assign wr         = acc & we;
    assign wr_ctrl    = wr & (adr[2:0] == REG_CTRL);
    assign wr_status  = wr & (adr[2:0] == REG_STATUS);
    assign wr_count   = wr & (adr[2:0] == REG_COUNT);
    assign wr_compare = wr & (adr[2:0] == REG_COMPARE);

    assign tick      = en & (pcnt == prescale);
    assign count_inc = count + 16'd1;
    assign hit       = tick & (count_inc == compare);

    assign irq = match & irq_en;

    // Read mux sees register values before this cycle's updates.
    always_comb begin
        rd_dat = '0;
        case (adr[2:0])
            REG_CTRL:    rd_dat = {prescale, 5'b0, irq_en, auto_reload, en};
            REG_STATUS:  rd_dat = {14'b0, en, match};
            REG_COUNT:   rd_dat = count;
            REG_COMPARE: rd_dat = compare;
            default:     rd_dat = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack   <= 1'b0;
            dat_o <= '0;
        end else begin
            ack <= acc;
            if (acc) begin
                dat_o <= rd_dat;
            end
        end
    end

    // A CTRL write overrides the one-shot auto-clear of EN in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            en          <= 1'b0;
            auto_reload <= 1'b0;
            irq_en      <= 1'b0;
            prescale    <= '0;
        end else if (wr_ctrl) begin
            en          <= dat_i[0];
            auto_reload <= dat_i[1];
            irq_en      <= dat_i[2];
            prescale    <= dat_i[15:8];
        end else if (hit && !auto_reload) begin
            en <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || wr_count || (wr_ctrl && !dat_i[0]) || !en || tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (wr_count) begin
            count <= dat_i;
        end else if (tick) begin
            count <= (hit && auto_reload) ? 16'd0 : count_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            compare <= 16'hFFFF;
        end else if (wr_compare) begin
            compare <= dat_i;
        end
    end

    // A match being set beats a write-1-clear landing in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            match <= 1'b0;
        end else if (hit) begin
            match <= 1'b1;
        end else if (wr_status && dat_i[0]) begin
            match <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_timer.sv
// Bench for wb_timer: directed bus vectors with literal expectations plus a per-cycle reference model.
`timescale 1ns/1ps
module tb_wb_timer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we  = 1'b0;
    logic [15:0] adr = 16'h0000;
    logic [15:0] dat_i = 16'h0000;
    logic [15:0] dat_o;
    logic        ack;
    logic        irq;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    wb_timer #(.BASE_ADR(16'h0000)) dut (
        .clk   (clk),
        .rst   (rst),
        .adr   (adr),
        .cyc   (cyc),
        .stb   (stb),
        .we    (we),
        .dat_i (dat_i),
        .dat_o (dat_o),
        .ack   (ack),
        .irq   (irq)
    );

    typedef struct {
        logic        en;
        logic        ar;
        logic        ie;
        logic [7:0]  ps;
        logic [7:0]  pcnt;
        logic [15:0] count;
        logic [15:0] cmp;
        logic        match;
        logic        ack;
        logic [15:0] dat;
    } mstate_t;

    mstate_t m;
    logic    m_valid = 1'b0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] m_read(input mstate_t s, input logic [2:0] r);
        logic [15:0] v;
        v = 16'h0000;
        case (r)
            3'd0: v = {s.ps, 5'd0, s.ie, s.ar, s.en};
            3'd1: v = {14'd0, s.en, s.match};
            3'd2: v = s.count;
            3'd3: v = s.cmp;
            default: v = 16'h0000;
        endcase
        return v;
    endfunction

    // One clock of the timer: counting happens first under the old controls,
    // then the bus write is applied on top, then a fresh match is recorded.
    function automatic mstate_t m_step(input mstate_t s, input logic r, input logic c,
                                       input logic st, input logic w,
                                       input logic [15:0] a, input logic [15:0] d);
        mstate_t n;
        logic    mine;
        logic    hit;
        int      nx;
        n   = s;
        hit = 1'b0;
        if (r) begin
            n.en = 1'b0; n.ar = 1'b0; n.ie = 1'b0; n.ps = 8'd0; n.pcnt = 8'd0;
            n.count = 16'h0000; n.cmp = 16'hFFFF; n.match = 1'b0;
            n.ack = 1'b0; n.dat = 16'h0000;
            return n;
        end
        mine = c && st && (a[15:3] == 13'd0);
        if (s.en) begin
            if (s.pcnt == s.ps) begin
                n.pcnt = 8'd0;
                nx = (int'(s.count) + 1) % 65536;
                if (nx == int'(s.cmp)) begin
                    hit = 1'b1;
                    n.count = s.ar ? 16'h0000 : 16'(nx);
                    if (!s.ar) n.en = 1'b0;
                end else begin
                    n.count = 16'(nx);
                end
            end else begin
                n.pcnt = s.pcnt + 8'd1;
            end
        end else begin
            n.pcnt = 8'd0;
        end
        if (mine && w) begin
            case (a[2:0])
                3'd0: begin
                    n.en = d[0]; n.ar = d[1]; n.ie = d[2]; n.ps = d[15:8];
                    if (!d[0]) n.pcnt = 8'd0;
                end
                3'd1: if (d[0]) n.match = 1'b0;
                3'd2: begin n.count = d; n.pcnt = 8'd0; end
                3'd3: n.cmp = d;
                default: ;
            endcase
        end
        if (hit) n.match = 1'b1;
        n.ack = mine;
        if (mine) n.dat = m_read(s, a[2:0]);
        return n;
    endfunction

    always @(posedge clk) begin
        m       <= m_step(m, rst, cyc, stb, we, adr, dat_i);
        m_valid <= 1'b1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("ack_model", 16'(ack), 16'(m.ack));
            check("irq_model", 16'(irq), 16'(m.match & m.ie));
            check("dat_o_model", dat_o, m.dat);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_wr(input logic [15:0] a, input logic [15:0] d);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; dat_i = d;
        @(posedge clk);
        #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        check("wr_ack", 16'(ack), 16'd1);
    endtask

    task automatic bus_rd(input logic [15:0] a, output logic [15:0] d);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a;
        @(posedge clk);
        #1;
        cyc = 1'b0; stb = 1'b0;
        check("rd_ack", 16'(ack), 16'd1);
        d = dat_o;
    endtask

    task automatic rd_expect(input string name, input logic [15:0] a, input logic [15:0] exp);
        logic [15:0] v;
        bus_rd(a, v);
        check(name, v, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] v1;
        logic [15:0] v2;
        logic [15:0] seq_a [8];
        logic [15:0] seq_b [5];
        logic [15:0] seq_c [5];

        seq_a = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd0, 16'd1, 16'd2};
        seq_b = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd1};
        seq_c = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001, 16'h0002};

        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        check("reset_ack", 16'(ack), 16'd0);
        check("reset_irq", 16'(irq), 16'd0);
        check("reset_dat_o", dat_o, 16'h0000);

        rd_expect("reset_ctrl", 16'd0, 16'h0000);
        rd_expect("reset_status", 16'd1, 16'h0000);
        rd_expect("reset_count", 16'd2, 16'h0000);
        rd_expect("reset_compare", 16'd3, 16'hFFFF);
        rd_expect("reset_rsvd4", 16'd4, 16'h0000);

        // Auto-reload at compare 5, prescale 0, back-to-back COUNT reads.
        bus_wr(16'd3, 16'd5);
        bus_wr(16'd0, 16'h0007);
        for (int i = 0; i < 8; i++) begin
            rd_expect($sformatf("ar_count_%0d", i), 16'd2, seq_a[i]);
        end
        check("ar_irq_high", 16'(irq), 16'd1);
        rd_expect("ar_status", 16'd1, 16'h0003);

        bus_wr(16'd3, 16'h1000);
        bus_wr(16'd1, 16'h0001);
        check("clr_irq_low", 16'(irq), 16'd0);
        rd_expect("clr_status", 16'd1, 16'h0002);
        bus_rd(16'd2, v1);
        bus_rd(16'd2, v2);
        check("clr_count_runs", v2, v1 + 16'd1);

        // One-shot with prescale 3.
        bus_wr(16'd0, 16'h0000);
        bus_wr(16'd2, 16'h0000);
        bus_wr(16'd3, 16'd3);
        bus_wr(16'd1, 16'h0001);
        bus_wr(16'd0, 16'h0301);
        for (int i = 0; i < 5; i++) begin
            rd_expect($sformatf("os_count_%0d", i), 16'd2, seq_b[i]);
        end
        idle(12);
        rd_expect("os_ctrl", 16'd0, 16'h0300);
        rd_expect("os_status", 16'd1, 16'h0001);
        rd_expect("os_count", 16'd2, 16'h0003);
        check("os_irq_low", 16'(irq), 16'd0);

        // Wrap through 0xFFFF.
        bus_wr(16'd0, 16'h0000);
        bus_wr(16'd2, 16'hFFFE);
        bus_wr(16'd3, 16'h0002);
        bus_wr(16'd1, 16'h0001);
        bus_wr(16'd0, 16'h0001);
        for (int i = 0; i < 5; i++) begin
            rd_expect($sformatf("wrap_count_%0d", i), 16'd2, seq_c[i]);
        end
        rd_expect("wrap_status", 16'd1, 16'h0001);

        // COUNT write landing on a tick.
        bus_wr(16'd0, 16'h0000);
        bus_wr(16'd2, 16'h0000);
        bus_wr(16'd3, 16'h1000);
        bus_wr(16'd0, 16'h0001);
        bus_wr(16'd2, 16'h0100);
        rd_expect("cw_count_0", 16'd2, 16'h0100);
        rd_expect("cw_count_1", 16'd2, 16'h0101);

        // STATUS clear landing on a match.
        bus_wr(16'd0, 16'h0000);
        bus_wr(16'd1, 16'h0001);
        bus_wr(16'd2, 16'h0000);
        bus_wr(16'd3, 16'h0002);
        bus_wr(16'd0, 16'h0003);
        idle(1);
        bus_wr(16'd1, 16'h0001);
        rd_expect("sc_status", 16'd1, 16'h0003);
        bus_wr(16'd0, 16'h0000);

        // Reserved registers and foreign addresses.
        bus_wr(16'd5, 16'hABCD);
        rd_expect("rsvd5", 16'd5, 16'h0000);
        rd_expect("rsvd7", 16'd7, 16'h0000);
        bus_wr(16'd2, 16'h0042);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 16'h000A; dat_i = 16'h5555;
        @(posedge clk);
        #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        check("foreign_no_ack", 16'(ack), 16'd0);
        cyc = 1'b0; stb = 1'b1; we = 1'b1; adr = 16'h0002; dat_i = 16'h7777;
        @(posedge clk);
        #1;
        stb = 1'b0; we = 1'b0;
        check("nocyc_no_ack", 16'(ack), 16'd0);
        rd_expect("foreign_count", 16'd2, 16'h0042);

        // Reset during a strobe while counting.
        bus_wr(16'd0, 16'h0001);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 16'd3; rst = 1'b1;
        @(posedge clk);
        #1;
        cyc = 1'b0; stb = 1'b0;
        check("rst_ack_dropped", 16'(ack), 16'd0);
        idle(1);
        rst = 1'b0;
        rd_expect("rst_count_0", 16'd2, 16'h0000);
        rd_expect("rst_count_1", 16'd2, 16'h0000);
        rd_expect("rst_ctrl", 16'd0, 16'h0000);
        rd_expect("rst_compare", 16'd3, 16'hFFFF);

        idle(2);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
